// File: rtl/beat_sequencer.sv
// Parametrised beat generator and opcode latch for the multicycle CPU control front end.
// Handles wait states, single-step, halt, overrun detection and retired-instruction counting.
module beat_sequencer #(
    parameter int NBEAT  = 8,
    parameter int NFETCH = 3,
    parameter int IW     = 8,
    parameter int OPW    = 4,
    parameter int CW     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               cpustate,
    input  logic [IW-1:0]            ir_din,
    input  logic                     last,
    input  logic                     wait_req,
    input  logic                     halt_req,
    input  logic                     step_mode,
    input  logic                     step_go,
    output logic [NBEAT-1:0]         t,
    output logic [$clog2(NBEAT)-1:0] beat_idx,
    output logic                     fetch,
    output logic                     exec,
    output logic                     irload,
    output logic [2**OPW-1:0]        op_dec,
    output logic                     clr,
    output logic                     halted,
    output logic                     ovf_err,
    output logic [CW-1:0]            instr_cnt
);

    localparam int BW  = $clog2(NBEAT);
    localparam int NOP = 2**OPW;
    localparam logic [BW-1:0] NF_BEATS  = BW'(NFETCH);
    localparam logic [BW-1:0] FETCH_END = BW'(NFETCH - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STEP_WAIT,
        S_HALT
    } state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] beat_nxt;
    logic          running;
    logic          active;
    logic          cnt_inc;
    logic          ovf_set;
    logic          op_load;
    logic          op_clear;

    assign running = (cpustate == 2'b11);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            beat_idx <= '0;
        end else begin
            state    <= state_nxt;
            beat_idx <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_idx;
        clr       = 1'b0;
        cnt_inc   = 1'b0;
        ovf_set   = 1'b0;
        op_load   = 1'b0;
        op_clear  = 1'b0;

        active = (state == S_RUN);
        fetch  = active && (beat_idx < NF_BEATS);
        exec   = active && !(beat_idx < NF_BEATS);
        irload = fetch && (beat_idx == FETCH_END);
        t      = active ? ({{(NBEAT-1){1'b0}}, 1'b1} << beat_idx) : '0;
        halted = (state == S_HALT);

        // Leaving RUN mode aborts from any non-idle state before any beat logic applies.
        if (state != S_IDLE && !running) begin
            state_nxt = S_IDLE;
            beat_nxt  = '0;
            op_clear  = 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (running) begin
                        state_nxt = S_RUN;
                        beat_nxt  = '0;
                    end
                end
                S_RUN: begin
                    if (!wait_req) begin
                        op_load = irload;
                        if (exec && last) begin
                            clr      = 1'b1;
                            cnt_inc  = 1'b1;
                            beat_nxt = '0;
                            if (halt_req)
                                state_nxt = S_HALT;
                            else if (step_mode)
                                state_nxt = S_STEP_WAIT;
                        end else if (exec && beat_idx == LAST_BEAT) begin
                            clr      = 1'b1;
                            ovf_set  = 1'b1;
                            beat_nxt = '0;
                        end else begin
                            beat_nxt = beat_idx + 1'b1;
                        end
                    end
                end
                S_STEP_WAIT: begin
                    if (step_go || !step_mode) begin
                        state_nxt = S_RUN;
                        beat_nxt  = '0;
                    end
                end
                S_HALT: begin
                    state_nxt = S_HALT;
                end
                default: begin
                    state_nxt = S_IDLE;
                    beat_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_dec <= '0;
        end else if (op_clear) begin
            op_dec <= '0;
        end else if (op_load) begin
            op_dec <= {{(NOP-1){1'b0}}, 1'b1} << ir_din[IW-1 -: OPW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_err   <= 1'b0;
            instr_cnt <= '0;
        end else begin
            if (ovf_set)
                ovf_err <= 1'b1;
            if (cnt_inc)
                instr_cnt <= instr_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_beat_sequencer.sv
// Scoreboard bench for beat_sequencer: a per-cycle reference model queues expected
// outputs, a negedge monitor compares them; a second instance covers an alternate configuration.
module tb_beat_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  cpustate = 2'b00;
    logic [7:0]  ir_din = 8'h00;
    logic        last = 1'b0, wait_req = 1'b0, halt_req = 1'b0, step_mode = 1'b0, step_go = 1'b0;
    logic [7:0]  t;
    logic [2:0]  beat_idx;
    logic        fetch, exec, irload, clr, halted, ovf_err;
    logic [15:0] op_dec, instr_cnt;

    logic        rst_b = 1'b1;
    logic [1:0]  cpustate_b = 2'b00;
    logic [7:0]  ir_b = 8'hA5;
    logic        last_b = 1'b0;
    logic        zero_b = 1'b0;
    logic [11:0] t_b;
    logic [3:0]  beat_idx_b;
    logic        fetch_b, exec_b, irload_b, clr_b, halted_b, ovf_err_b;
    logic [15:0] op_dec_b;
    logic [3:0]  instr_cnt_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    beat_sequencer dut (
        .clk(clk), .rst(rst), .cpustate(cpustate), .ir_din(ir_din), .last(last),
        .wait_req(wait_req), .halt_req(halt_req), .step_mode(step_mode), .step_go(step_go),
        .t(t), .beat_idx(beat_idx), .fetch(fetch), .exec(exec), .irload(irload),
        .op_dec(op_dec), .clr(clr), .halted(halted), .ovf_err(ovf_err), .instr_cnt(instr_cnt)
    );

    beat_sequencer #(.NBEAT(12), .NFETCH(2), .IW(8), .OPW(4), .CW(4)) dut_b (
        .clk(clk), .rst(rst_b), .cpustate(cpustate_b), .ir_din(ir_b), .last(last_b),
        .wait_req(zero_b), .halt_req(zero_b), .step_mode(zero_b), .step_go(zero_b),
        .t(t_b), .beat_idx(beat_idx_b), .fetch(fetch_b), .exec(exec_b), .irload(irload_b),
        .op_dec(op_dec_b), .clr(clr_b), .halted(halted_b), .ovf_err(ovf_err_b), .instr_cnt(instr_cnt_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0]  t;
        logic [2:0]  bi;
        logic        f, e, irl, clr, hl, ovf;
        logic [15:0] op, cnt;
    } exp_t;

    exp_t sb[$];
    exp_t got_e;

    // reference model state: 0 idle, 1 run, 2 step-wait, 3 halt
    int          m_state = 0;
    int          m_beat = 0;
    logic [15:0] m_op = '0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_cnt = '0;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            got_e = sb.pop_front();
            check("t", t, got_e.t);
            check("beat_idx", beat_idx, got_e.bi);
            check("fetch", fetch, got_e.f);
            check("exec", exec, got_e.e);
            check("irload", irload, got_e.irl);
            check("clr", clr, got_e.clr);
            check("halted", halted, got_e.hl);
            check("ovf_err", ovf_err, got_e.ovf);
            check("op_dec", op_dec, got_e.op);
            check("instr_cnt", instr_cnt, got_e.cnt);
        end
    end

    task automatic model_step();
        logic is_exec;
        is_exec = (m_state == 1) && (m_beat >= 3);
        if (m_state != 0 && cpustate != 2'b11) begin
            m_state = 0; m_beat = 0; m_op = '0;
        end else if (m_state == 0) begin
            if (cpustate == 2'b11) begin m_state = 1; m_beat = 0; end
        end else if (m_state == 1) begin
            if (!wait_req) begin
                if (m_beat == 2) m_op = 16'(1) << ir_din[7:4];
                if (is_exec && last) begin
                    m_cnt++;
                    m_beat = 0;
                    if (halt_req) m_state = 3;
                    else if (step_mode) m_state = 2;
                end else if (is_exec && m_beat == 7) begin
                    m_ovf = 1'b1;
                    m_beat = 0;
                end else begin
                    m_beat++;
                end
            end
        end else if (m_state == 2) begin
            if (step_go || !step_mode) begin m_state = 1; m_beat = 0; end
        end
    endtask

    // Called just after a rising edge with inputs for this cycle already driven.
    task automatic tick();
        exp_t e;
        logic run;
        if (rst) begin
            m_state = 0; m_beat = 0; m_op = '0; m_ovf = 1'b0; m_cnt = '0;
        end
        run   = (m_state == 1);
        e.t   = run ? (8'(1) << m_beat) : 8'h00;
        e.bi  = 3'(m_beat);
        e.f   = run && m_beat < 3;
        e.e   = run && m_beat >= 3;
        e.irl = run && m_beat == 2;
        e.clr = run && cpustate == 2'b11 && !wait_req && m_beat >= 3 && (last || m_beat == 7);
        e.hl  = (m_state == 3);
        e.ovf = m_ovf;
        e.op  = m_op;
        e.cnt = m_cnt;
        sb.push_back(e);
        @(negedge clk);
        #1;
        if (!rst) model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycles(input int n, input int lb);
        for (int i = 0; i < n; i++) begin
            last = (m_state == 1) && (m_beat == lb);
            tick();
        end
        last = 1'b0;
    endtask

    task automatic step_b(input int k, input logic lst);
        last_b = lst;
        @(negedge clk);
        check("b_t", t_b, 12'(1) << k);
        check("b_irload", irload_b, k == 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w, wl;
        @(posedge clk);
        #1;
        tick();
        tick();
        rst = 1'b0;
        rst_b = 1'b0;

        // basic instruction, retire at beat 5
        cpustate = 2'b11;
        ir_din = 8'h12;
        run_cycles(7, 5);
        check("t1_cnt", instr_cnt, 16'd1);
        check("t1_op", op_dec, 16'h0002);

        // wait states in fetch and on the retirement beat
        ir_din = 8'h34;
        w = 3; wl = 1;
        for (int i = 0; i < 11; i++) begin
            wait_req = (m_beat == 1 && w > 0) || (m_beat == 5 && wl > 0);
            if (m_beat == 1 && w > 0) w--;
            else if (m_beat == 5 && wl > 0) wl--;
            last = (m_beat == 5);
            tick();
        end
        wait_req = 1'b0;
        last = 1'b0;
        check("t2_cnt", instr_cnt, 16'd2);
        check("t2_op", op_dec, 16'h0008);

        // overrun, then a normal instruction
        ir_din = 8'h70;
        run_cycles(8, 99);
        check("t3_ovf", ovf_err, 1'b1);
        check("t3_cnt", instr_cnt, 16'd2);
        check("t3_op", op_dec, 16'h0080);
        run_cycles(6, 5);
        check("t3_cnt2", instr_cnt, 16'd3);
        check("t3_ovf2", ovf_err, 1'b1);

        // single step
        step_mode = 1'b1;
        run_cycles(4, 3);
        run_cycles(3, 99);
        step_go = 1'b1;
        tick();
        step_go = 1'b0;
        run_cycles(4, 3);
        check("t4_cnt", instr_cnt, 16'd5);
        step_mode = 1'b0;
        run_cycles(2, 99);

        // finish current instruction, then halt beats step at retirement
        run_cycles(4, 3);
        halt_req = 1'b1;
        step_mode = 1'b1;
        run_cycles(4, 3);
        check("t5_halted", halted, 1'b1);
        step_go = 1'b1;
        tick();
        step_go = 1'b0;
        run_cycles(2, 99);
        check("t5_halted2", halted, 1'b1);
        halt_req = 1'b0;
        step_mode = 1'b0;
        cpustate = 2'b00;
        tick();
        check("t5_idle", halted, 1'b0);
        cpustate = 2'b11;
        tick();
        run_cycles(4, 3);
        check("t5_cnt", instr_cnt, 16'd8);

        // abort mid-instruction
        ir_din = 8'hF0;
        run_cycles(4, 99);
        cpustate = 2'b01;
        tick();
        check("t7_op", op_dec, 16'h0000);
        check("t7_cnt", instr_cnt, 16'd8);
        cpustate = 2'b11;
        run_cycles(3, 99);

        @(negedge clk);
        check("sb_drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;

        // alternate configuration: counter wrap and async reset mid-instruction
        cpustate_b = 2'b11;
        @(posedge clk);
        #1;
        for (int n = 0; n < 17; n++)
            for (int k = 0; k < 4; k++)
                step_b(k, k == 3);
        check("b_cnt_wrap", instr_cnt_b, 4'd1);
        check("b_op", op_dec_b, 16'h0400);
        for (int k = 0; k < 6; k++)
            step_b(k, 1'b0);
        check("b_t6", t_b, 12'h040);
        #2;
        rst_b = 1'b1;
        #1;
        check("b_rst_t", t_b, 12'h000);
        check("b_rst_beat", beat_idx_b, 4'd0);
        check("b_rst_op", op_dec_b, 16'h0000);
        check("b_rst_cnt", instr_cnt_b, 4'd0);
        check("b_rst_clr", clr_b, 1'b0);
        check("b_rst_ovf", ovf_err_b, 1'b0);
        check("b_rst_halted", halted_b, 1'b0);
        rst_b = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
